// File: rtl/alu_unit_if.sv
// Operand/opcode/result bundle for alu_unit.
// Defining ALU_FLAGS_EN adds the zero/carry/overflow flag signals.
interface alu_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] input_a;
    logic [WIDTH-1:0] input_b;
    logic [1:0]       op;
    logic             en;
    logic [WIDTH-1:0] result;
`ifdef ALU_FLAGS_EN
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output input_a, input_b, op, en,
        input  result, zero, carry, overflow
    );
    modport slave (
        input  input_a, input_b, op, en,
        output result, zero, carry, overflow
    );
`else
    modport master (
        output input_a, input_b, op, en,
        input  result
    );
    modport slave (
        input  input_a, input_b, op, en,
        output result
    );
`endif
endinterface

// File: rtl/alu_unit.sv
// Registered integer ALU (ADD/SUB/AND/OR) with one cycle of latency.
// Defining ALU_FLAGS_EN adds registered zero/carry/overflow flags.
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_unit_if.slave  bus
);

    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;

    // OR sits in the default arm so an unknown opcode still resolves without a latch.
    always_comb begin
        result_next = '0;
        case (bus.op)
            2'd0:    result_next = bus.input_a + bus.input_b;
            2'd1:    result_next = bus.input_a - bus.input_b;
            2'd2:    result_next = bus.input_a & bus.input_b;
            default: result_next = bus.input_a | bus.input_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg <= '0;
        end else if (bus.en) begin
            result_reg <= result_next;
        end
    end

    assign bus.result = result_reg;

`ifdef ALU_FLAGS_EN
    logic zero_reg,     zero_next;
    logic carry_reg,    carry_next;
    logic overflow_reg, overflow_next;
    logic sign_a, sign_b, sign_r;

    // Carry of an addition shows up as the wrapped sum being smaller than an operand.
    always_comb begin
        sign_a        = bus.input_a[WIDTH-1];
        sign_b        = bus.input_b[WIDTH-1];
        sign_r        = result_next[WIDTH-1];
        zero_next     = (result_next == '0);
        carry_next    = 1'b0;
        overflow_next = 1'b0;
        case (bus.op)
            2'd0: begin
                carry_next    = (result_next < bus.input_a);
                overflow_next = (sign_a == sign_b) && (sign_r != sign_a);
            end
            2'd1: begin
                carry_next    = (bus.input_a >= bus.input_b);
                overflow_next = (sign_a != sign_b) && (sign_r != sign_a);
            end
            default: begin
                carry_next    = 1'b0;
                overflow_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_reg     <= 1'b0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (bus.en) begin
            zero_reg     <= zero_next;
            carry_reg    <= carry_next;
            overflow_reg <= overflow_next;
        end
    end

    assign bus.zero     = zero_reg;
    assign bus.carry    = carry_reg;
    assign bus.overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus randomized traffic
// compared against an arithmetic reference model (flags when ALU_FLAGS_EN).
module tb_alu_unit;

    localparam int WIDTH = 32;
    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [31:0] exp_result;
    logic        exp_zero;
    logic        exp_carry;
    logic        exp_overflow;

    alu_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        case (op)
            2'd0:    return 32'((ua + ub) % MOD);
            2'd1:    return 32'((ua + MOD - ub) % MOD);
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic logic ref_carry(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        if (op == 2'd0) return (ua + ub) >= MOD;
        if (op == 2'd1) return ua >= ub;
        return 1'b0;
    endfunction

    function automatic logic ref_overflow(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        if (op == 2'd0)      s = sa + sb;
        else if (op == 2'd1) s = sa - sb;
        else                 return 1'b0;
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Advance one clock edge, update the model from the sampled inputs, and compare.
    task automatic tick(input string tag);
        if (reset) begin
            exp_result   = '0;
            exp_zero     = 1'b0;
            exp_carry    = 1'b0;
            exp_overflow = 1'b0;
        end else if (bus.en) begin
            exp_result   = ref_result(bus.op, bus.input_a, bus.input_b);
            exp_zero     = (exp_result == 32'd0);
            exp_carry    = ref_carry(bus.op, bus.input_a, bus.input_b);
            exp_overflow = ref_overflow(bus.op, bus.input_a, bus.input_b);
        end
        @(posedge clk);
        #1;
        check_value({tag, "_result"}, bus.result, exp_result);
`ifdef ALU_FLAGS_EN
        check_value({tag, "_zero"}, 32'(bus.zero), 32'(exp_zero));
        check_value({tag, "_carry"}, 32'(bus.carry), 32'(exp_carry));
        check_value({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_overflow));
`endif
        $display("txn %s: reset=%0b en=%0b op=%0d a=%08h b=%08h result=%08h",
                 tag, reset, bus.en, bus.op, bus.input_a, bus.input_b, bus.result);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        errors       = 0;
        checks       = 0;
        exp_result   = '0;
        exp_zero     = 1'b0;
        exp_carry    = 1'b0;
        exp_overflow = 1'b0;

        // Reset overrides en.
        reset       = 1'b1;
        bus.en      = 1'b1;
        bus.op      = 2'd0;
        bus.input_a = 32'd5;
        bus.input_b = 32'd3;
        tick("reset0");
        tick("reset1");
        check_value("reset_const", bus.result, 32'd0);
        reset = 1'b0;
        tick("first_add");
        check_value("first_add_const", bus.result, 32'd8);

        bus.input_a = 32'd19260817;
        bus.input_b = 32'd99999999;
        tick("add_big");
        check_value("add_big_const", bus.result, 32'd119260816);

        // Opcode change mid-cycle must not reach the output before the edge.
        #2;
        bus.op = 2'd1;
        #1;
        check_value("sub_mid_hold", bus.result, 32'd119260816);
        tick("sub_big");
        check_value("sub_big_const", bus.result, 32'hFB30_0492);

        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.input_a = 32'd100 + 32'(i);
            bus.op      = 2'(i + 2);
            tick("hold");
            check_value("hold_const", bus.result, 32'hFB30_0492);
        end

        bus.en      = 1'b1;
        bus.op      = 2'd0;
        bus.input_a = 32'hFFFF_FFFF;
        bus.input_b = 32'd1;
        tick("add_wrap");
        check_value("add_wrap_const", bus.result, 32'd0);

        bus.op      = 2'd2;
        bus.input_a = 32'hF0F0_F0F0;
        bus.input_b = 32'hFF00_FF00;
        tick("and");
        check_value("and_const", bus.result, 32'hF000_F000);
        bus.op = 2'd3;
        tick("or");
        check_value("or_const", bus.result, 32'hFFF0_FFF0);

        bus.op      = 2'd1;
        bus.input_a = 32'h8000_0000;
        bus.input_b = 32'd1;
        tick("sub_ovf");
        check_value("sub_ovf_const", bus.result, 32'h7FFF_FFFF);

        for (int n = 0; n < 300; n++) begin
            reset       = ($urandom_range(0, 15) == 0);
            bus.en      = ($urandom_range(0, 3) != 0);
            bus.op      = 2'($urandom_range(0, 3));
            bus.input_a = rand_operand();
            bus.input_b = rand_operand();
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
